palindrome_stream_tx: RTL and testbench

- Transmit end of the byte-stream palindrome-check interface.
- Buffers one string from a host write port, optionally mirrors it into a palindrome, and streams it byte-by-byte to the checker using the checker's ready/valid protocol.
- Waits for the checker's verdict, then returns the result with a string counter.
- Sits between the host/stimulus source and the palindrome checker.

---
 rtl/palindrome_pkg.sv | 48 ++++
 rtl/tx_byte_buffer.sv | 35 +++
 rtl/palindrome_stream_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_palindrome_stream_tx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palindrome_pkg.sv
// palindrome_pkg
// Shared types and constants for the palindrome transmit block.
//   tx_state_e    : transmit FSM states (also exported on the debug port)
//   mirror_mode_e : how the buffered string is expanded before streaming
//   tx_result_t   : result bundle returned to the host after each string
//   to_mode()     : maps the raw 2-bit host mode field onto mirror_mode_e
package palindrome_pkg;

    localparam int BYTE_W      = 8;

    // Default geometry; the result struct is sized from these.
    localparam int DEF_MAX_LEN = 64;
    localparam int DEF_CNT_W   = 16;
    localparam int RES_LEN_W   = $clog2(2 * DEF_MAX_LEN) + 1;
    localparam int RES_CNT_W   = DEF_CNT_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SEND     = 3'd2,
        WAIT_RES = 3'd3,
        REPORT   = 3'd4
    } tx_state_e;

    typedef enum logic [1:0] {
        PLAIN = 2'd0,
        EVEN  = 2'd1,
        ODD   = 2'd2
    } mirror_mode_e;

    typedef struct packed {
        logic                 palin;
        logic                 ovfl;
        logic                 timeout;
        logic [RES_LEN_W-1:0] len;
        logic [RES_CNT_W-1:0] count;
    } tx_result_t;

    // Encoding 3 is unused by the host and behaves like PLAIN.
    function automatic mirror_mode_e to_mode(input logic [1:0] m);
        case (m)
            2'd1:    return EVEN;
            2'd2:    return ODD;
            default: return PLAIN;
        endcase
    endfunction

endpackage

// File: rtl/tx_byte_buffer.sv
// tx_byte_buffer
// DEPTH x 8 register array: one synchronous write port, one combinational
// read port, so the read data follows the read address in the same cycle.
// Contents are not reset; every location is written before it is read.
//   i_clk       : clock, rising edge
//   i_wr_en     : write strobe
//   i_wr_addr   : write address
//   i_wr_data   : write byte
//   i_rd_addr   : read address
//   o_rd_data   : byte at i_rd_addr
module tx_byte_buffer
    import palindrome_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [BYTE_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [BYTE_W-1:0] o_rd_data
);

    logic [BYTE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/palindrome_stream_tx.sv
// palindrome_stream_tx
// Buffers one host string, optionally mirrors it into a palindrome, streams
// it to the palindrome checker, waits for the verdict and reports it.
//   clock, resetN          : clock (rising edge), async active-low reset
//   wrData/wrVld/wrLast    : host write beat; wrLast marks the final byte
//   mirrorMode             : expansion mode, sampled with the wrLast beat
//   wrReady                : host may write (IDLE/LOAD)
//   dataIn/dataVld/ready   : byte stream to the checker
//   isTrue/dataOvfl/outVld : checker verdict
//   resVld                 : one-cycle result strobe
//   resPalin/resOvfl/resTimeout/resLen/resCount : result, held until next
//   dbgState               : current FSM state
//
// Checker handshake: a byte moves on a rising edge where dataVld=1 and
// ready=1. Once dataVld rises it stays high with dataIn stable until the
// byte moves; dataVld drops the cycle after the final byte moves, and that
// falling edge is the end-of-string marker for the checker.
module palindrome_stream_tx
    import palindrome_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic [BYTE_W-1:0]          wrData,
    input  logic                       wrVld,
    input  logic                       wrLast,
    input  logic [1:0]                 mirrorMode,
    output logic                       wrReady,
    output logic [BYTE_W-1:0]          dataIn,
    output logic                       dataVld,
    input  logic                       ready,
    input  logic                       isTrue,
    input  logic                       dataOvfl,
    input  logic                       outVld,
    output logic                       resVld,
    output logic                       resPalin,
    output logic                       resOvfl,
    output logic                       resTimeout,
    output logic [$clog2(2*MAX_LEN):0] resLen,
    output logic [CNT_W-1:0]           resCount,
    output tx_state_e                  dbgState
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int NW = AW + 1;
    localparam int LW = $clog2(2 * MAX_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] ONE_A = 1;
    localparam logic [NW-1:0] ONE_N = 1;
    localparam logic [LW-1:0] ONE_L = 1;
    localparam logic [TW-1:0] ONE_T = 1;

    tx_state_e         r_state;
    tx_state_e         w_next;
    logic              r_wr_ready;
    logic [NW-1:0]     r_n;          // bytes stored, saturates at MAX_LEN
    logic              r_load_ovfl;
    mirror_mode_e      r_mode;
    logic [LW-1:0]     r_total;      // beats to send for this string
    logic [LW-1:0]     r_sent;       // beats already transferred
    logic [AW-1:0]     r_rd_idx;
    logic              r_down;       // read index is walking back to 0
    logic [TW-1:0]     r_tmo;
    tx_result_t        r_res;

    logic              w_wr_fire;
    logic              w_wr_en;
    logic [NW-1:0]     w_n_after;
    logic [LW-1:0]     w_n_ext;
    logic [LW-1:0]     w_total;
    logic              w_tx_fire;
    logic              w_last_beat;
    logic              w_at_turn;
    logic              w_tmo_hit;
    logic              w_verdict;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [BYTE_W-1:0] w_rd_data;

    tx_byte_buffer #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .i_clk     (clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_n[AW-1:0]),
        .i_wr_data (wrData),
        .i_rd_addr (r_rd_idx),
        .o_rd_data (w_rd_data)
    );

    // r_wr_ready is only high in IDLE/LOAD, so this also gates by state.
    assign w_wr_fire   = wrVld & r_wr_ready;
    // Beats past MAX_LEN are accepted but not stored.
    assign w_wr_en     = w_wr_fire && (r_n < NW'(MAX_LEN));
    assign w_n_after   = w_wr_en ? (r_n + ONE_N) : r_n;
    assign w_tx_fire   = (r_state == SEND) && ready;
    assign w_last_beat = w_tx_fire && ((r_sent + ONE_L) == r_total);
    assign w_at_turn   = ({1'b0, r_rd_idx} == (r_n - ONE_N));
    assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT));
    assign w_verdict   = (r_state == WAIT_RES) && (outVld || w_tmo_hit);
    assign w_cnt_next  = CNT_W'(r_res.count) + CNT_W'(1);

    // Beat count for the string being closed by the current wrLast beat.
    always_comb begin
        w_n_ext = LW'(w_n_after);
        case (to_mode(mirrorMode))
            EVEN:    w_total = w_n_ext << 1;
            ODD:     w_total = (w_n_ext << 1) - ONE_L;
            default: w_total = w_n_ext;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, LOAD: begin
                if (w_wr_fire) begin
                    w_next = wrLast ? SEND : LOAD;
                end
            end
            SEND: begin
                if (w_last_beat) begin
                    w_next = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (outVld || w_tmo_hit) begin
                    w_next = REPORT;
                end
            end
            REPORT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state     <= IDLE;
            r_wr_ready  <= 1'b0;
            r_n         <= '0;
            r_load_ovfl <= 1'b0;
            r_mode      <= PLAIN;
            r_total     <= '0;
            r_sent      <= '0;
            r_rd_idx    <= '0;
            r_down      <= 1'b0;
            r_tmo       <= '0;
            r_res       <= '0;
        end else begin
            r_state    <= w_next;
            r_wr_ready <= (w_next == IDLE) || (w_next == LOAD);
            case (r_state)
                IDLE, LOAD: begin
                    if (w_wr_fire) begin
                        r_n <= w_n_after;
                        if (!w_wr_en) begin
                            r_load_ovfl <= 1'b1;
                        end
                        if (wrLast) begin
                            r_mode   <= to_mode(mirrorMode);
                            r_total  <= w_total;
                            r_sent   <= '0;
                            r_rd_idx <= '0;
                            r_down   <= 1'b0;
                        end
                    end
                end
                SEND: begin
                    if (w_tx_fire) begin
                        r_sent <= r_sent + ONE_L;
                        if (w_last_beat) begin
                            r_tmo <= '0;
                        end else if (r_down) begin
                            r_rd_idx <= r_rd_idx - ONE_A;
                        end else if (w_at_turn) begin
                            // Even mirror repeats the centre byte, odd skips it.
                            r_down <= 1'b1;
                            if (r_mode == ODD) begin
                                r_rd_idx <= r_rd_idx - ONE_A;
                            end
                        end else begin
                            r_rd_idx <= r_rd_idx + ONE_A;
                        end
                    end
                end
                WAIT_RES: begin
                    r_tmo <= r_tmo + ONE_T;
                    if (w_verdict) begin
                        // A verdict arriving on the terminal count still wins.
                        r_res.palin   <= outVld & isTrue;
                        r_res.ovfl    <= (outVld & dataOvfl) | r_load_ovfl;
                        r_res.timeout <= ~outVld;
                        r_res.len     <= RES_LEN_W'(r_sent);
                        r_res.count   <= RES_CNT_W'(w_cnt_next);
                    end
                end
                REPORT: begin
                    r_n         <= '0;
                    r_load_ovfl <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign wrReady    = r_wr_ready;
    assign dataVld    = (r_state == SEND);
    assign dataIn     = dataVld ? w_rd_data : '0;
    assign resVld     = (r_state == REPORT);
    assign resPalin   = r_res.palin;
    assign resOvfl    = r_res.ovfl;
    assign resTimeout = r_res.timeout;
    assign resLen     = LW'(r_res.len);
    assign resCount   = CNT_W'(r_res.count);
    assign dbgState   = r_state;

endmodule

// File: tb/tb_palindrome_stream_tx.sv
module tb_palindrome_stream_tx;
    import palindrome_pkg::*;

    localparam int MAX_LEN = 64;
    localparam int TIMEOUT = 40;
    localparam int CNT_W   = 16;
    localparam int LW      = $clog2(2 * MAX_LEN) + 1;

    // ---------------- clock / reset / signals ----------------
    logic             clock = 1'b0;
    logic             resetN = 1'b0;
    logic [7:0]       wrData = '0;
    logic             wrVld = 1'b0;
    logic             wrLast = 1'b0;
    logic [1:0]       mirrorMode = '0;
    logic             wrReady;
    logic [7:0]       dataIn;
    logic             dataVld;
    logic             ready = 1'b0;
    logic             isTrue = 1'b0;
    logic             dataOvfl = 1'b0;
    logic             outVld = 1'b0;
    logic             resVld;
    logic             resPalin;
    logic             resOvfl;
    logic             resTimeout;
    logic [LW-1:0]    resLen;
    logic [CNT_W-1:0] resCount;
    tx_state_e        dbgState;

    always #5 clock = ~clock;

    palindrome_stream_tx #(
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clock      (clock),
        .resetN     (resetN),
        .wrData     (wrData),
        .wrVld      (wrVld),
        .wrLast     (wrLast),
        .mirrorMode (mirrorMode),
        .wrReady    (wrReady),
        .dataIn     (dataIn),
        .dataVld    (dataVld),
        .ready      (ready),
        .isTrue     (isTrue),
        .dataOvfl   (dataOvfl),
        .outVld     (outVld),
        .resVld     (resVld),
        .resPalin   (resPalin),
        .resOvfl    (resOvfl),
        .resTimeout (resTimeout),
        .resLen     (resLen),
        .resCount   (resCount),
        .dbgState   (dbgState)
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] wr_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_str(input string s);
        wr_q.delete();
        for (int i = 0; i < s.len(); i++) wr_q.push_back(s[i]);
    endtask

    task automatic exp_str(input string s);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic write_string(input logic [1:0] mode);
        for (int i = 0; i < wr_q.size(); i++) begin
            @(negedge clock);
            check("wr_ready", 32'(wrReady), 1);
            wrVld      = 1'b1;
            wrData     = wr_q[i];
            wrLast     = (i == wr_q.size() - 1);
            mirrorMode = mode;
        end
    endtask

    // rdy_mode 0: ready held high; 1: ready pattern 1,0,0,1,0,0,...
    task automatic collect(input int n_exp, input int rdy_mode);
        int         got = 0;
        int         cyc = 0;
        logic       stalled = 1'b0;
        logic [7:0] held = '0;
        while (got < n_exp && cyc < 400) begin
            @(negedge clock);
            wrVld  = 1'b0;
            wrLast = 1'b0;
            ready  = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
            #1;
            check("vld_hold", 32'(dataVld), 1);
            if (stalled) check("stall_hold", 32'(dataIn), 32'(held));
            stalled = dataVld && !ready;
            held    = dataIn;
            if (dataVld && ready) begin
                check("beat", 32'(dataIn), 32'(exp_q.pop_front()));
                got++;
            end
            cyc++;
        end
        check("beat_cnt", got, n_exp);
        @(negedge clock);
        ready = 1'b1;
        #1;
        check("eos_vld", 32'(dataVld), 0);
    endtask

    task automatic verdict(input logic t, input logic ov, input int e_palin,
                           input int e_ovfl, input int e_len, input int e_cnt);
        repeat (2) begin
            @(negedge clock);
            #1;
            check("no_early_res", 32'(resVld), 0);
        end
        @(negedge clock);
        outVld   = 1'b1;
        isTrue   = t;
        dataOvfl = ov;
        @(negedge clock);
        outVld   = 1'b0;
        isTrue   = 1'b0;
        dataOvfl = 1'b0;
        #1;
        check("res_vld", 32'(resVld), 1);
        check("res_palin", 32'(resPalin), e_palin);
        check("res_ovfl", 32'(resOvfl), e_ovfl);
        check("res_tmo", 32'(resTimeout), 0);
        check("res_len", 32'(resLen), e_len);
        check("res_cnt", 32'(resCount), e_cnt);
        @(negedge clock);
        #1;
        check("res_pulse", 32'(resVld), 0);
        check("res_len_hold", 32'(resLen), e_len);
        check("wr_ready_idle", 32'(wrReady), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;

        repeat (3) @(negedge clock);
        #1;
        check("rst_wr_ready", 32'(wrReady), 0);
        check("rst_data_vld", 32'(dataVld), 0);
        check("rst_data_in", 32'(dataIn), 0);
        check("rst_res_vld", 32'(resVld), 0);
        check("rst_res_len", 32'(resLen), 0);
        check("rst_res_cnt", 32'(resCount), 0);
        check("rst_state", 32'(dbgState), 32'(IDLE));
        resetN = 1'b1;
        @(negedge clock);
        #1;
        check("post_rst_wr_ready", 32'(wrReady), 1);

        // "abba" plain, ready always high, verdict true
        load_str("abba"); exp_str("abba");
        write_string(2'd0);
        collect(4, 0);
        verdict(1'b1, 1'b0, 1, 0, 4, 1);

        // "abc" odd mirror -> abcba
        load_str("abc"); exp_str("abcba");
        write_string(2'd2);
        collect(5, 0);
        verdict(1'b1, 1'b0, 1, 0, 5, 2);

        // "abc" even mirror -> abccba
        load_str("abc"); exp_str("abccba");
        write_string(2'd1);
        collect(6, 0);
        verdict(1'b1, 1'b0, 1, 0, 6, 3);

        // "hello" plain with stalls, verdict false
        load_str("hello"); exp_str("hello");
        write_string(2'd0);
        collect(5, 1);
        verdict(1'b0, 1'b0, 0, 0, 5, 4);

        // 70 bytes into a 64-byte buffer: first 64 streamed, local overflow
        wr_q.delete();
        exp_q.delete();
        for (int i = 0; i < 70; i++) wr_q.push_back(8'(i + 1));
        for (int i = 0; i < 64; i++) exp_q.push_back(8'(i + 1));
        write_string(2'd0);
        collect(64, 0);
        verdict(1'b0, 1'b0, 0, 1, 64, 5);

        // no verdict: timeout after TIMEOUT+1 cycles in WAIT_RES
        load_str("xy"); exp_str("xy");
        write_string(2'd0);
        collect(2, 0);
        k = 0;
        for (int c = 1; c <= TIMEOUT + 10; c++) begin
            @(negedge clock);
            #1;
            if (resVld) begin
                k = c;
                break;
            end
        end
        check("tmo_latency", k, TIMEOUT + 1);
        check("tmo_flag", 32'(resTimeout), 1);
        check("tmo_palin", 32'(resPalin), 0);
        check("tmo_ovfl", 32'(resOvfl), 0);
        check("tmo_len", 32'(resLen), 2);
        check("tmo_cnt", 32'(resCount), 6);

        // mode 3 behaves as plain; string after timeout proceeds normally
        load_str("ada"); exp_str("ada");
        write_string(2'd3);
        collect(3, 0);
        verdict(1'b1, 1'b0, 1, 0, 3, 7);

        // verdict outside WAIT_RES is ignored
        @(negedge clock);
        outVld = 1'b1;
        isTrue = 1'b1;
        @(negedge clock);
        outVld = 1'b0;
        isTrue = 1'b0;
        #1;
        check("stray_out_vld", 32'(resVld), 0);
        check("stray_cnt", 32'(resCount), 7);

        // reset during the 3rd SEND beat
        load_str("abcde");
        write_string(2'd0);
        @(negedge clock);
        wrVld  = 1'b0;
        wrLast = 1'b0;
        ready  = 1'b1;
        #1;
        check("abort_b0", 32'(dataIn), 32'h61);
        @(negedge clock);
        #1;
        check("abort_b1", 32'(dataIn), 32'h62);
        @(negedge clock);
        #1;
        check("abort_b2", 32'(dataIn), 32'h63);
        resetN = 1'b0;
        #1;
        check("abort_vld", 32'(dataVld), 0);
        check("abort_data", 32'(dataIn), 0);
        check("abort_wr_ready", 32'(wrReady), 0);
        check("abort_res_vld", 32'(resVld), 0);
        check("abort_cnt", 32'(resCount), 0);
        @(negedge clock);
        resetN = 1'b1;
        repeat (4) begin
            @(negedge clock);
            #1;
            check("abort_no_res", 32'(resVld), 0);
        end
        check("abort_idle_ready", 32'(wrReady), 1);

        load_str("aa"); exp_str("aa");
        write_string(2'd0);
        collect(2, 0);
        verdict(1'b1, 1'b0, 1, 0, 2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
